ctrl_pipe_unit: RTL and testbench
=================================

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL have parameter N_STAGES, default 3; number of control-register stages from EX to WB, legal range 2..5.
REQ-002 SHALL have parameter COND_EN, default 1; 1 = evaluate IR[31:28] condition, 0 = every instruction is treated as AL.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 ir  in  32  instruction in ID.
REQ-007 ir_valid  in  1  ir holds a real instruction; 0 = bubble.
REQ-008 stall  in  1  global freeze from memory/IF.
REQ-009 flags  in  4  NZCV from the status register.
REQ-010 ex_op  out  4  ALU opcode in EX.
REQ-011 ex_sm, ex_mm  out  2 each  shifter mode and memory size in EX.
REQ-012 ex_load, ex_rf_we, ex_mem_we, ex_data, ex_shift_imm  out  1 each  EX control bits.
REQ-013 ex_rd  out  4  destination register in EX.
REQ-014 wb_rf_we, wb_load  out  1 each; wb_rd  out  4; all taken from the last stage (N_STAGES).
REQ-015 hazard  out  1  combinational load-use stall request to IF/ID.
REQ-016 branch_taken  out  1  registered; a branch in EX passed its condition.

Function
REQ-017 Decode SHALL be combinational to a control word (op, sm, mm, load, rf_we, mem_we, data, shift_imm, b, rd = IR[15:12]).
REQ-018 Bubble word SHALL be all zeros; it SHALL be used for ir = 0, ir_valid = 0, undefined class, and a failed condition.
REQ-019 Data processing (IR[27:26] = 00): op = IR[24:21], rf_we = 1. IR[25] = 1 -> sm 00, shift_imm 1. IR[25] = 0 -> sm 01, shift_imm = (IR[11:4] != 0).
REQ-020 Load/store (IR[27:26] = 01): op = 0100 if IR[23] else 0010; sm 10; mm = 10 if IR[22] = 0 else 00; data 1; load = rf_we = IR[20]; mem_we = !IR[20].
REQ-021 Load/store shift_imm SHALL be 1 if IR[25] = 0, else (IR[11:4] != 0).
REQ-022 Branch (IR[27:25] = 101): b = 1, all other bits 0.
REQ-023 Condition evaluation SHALL follow ARM codes 0000..1110 on NZCV; 1111 SHALL be treated as never.
REQ-024 hazard SHALL be 1 when ex_load = 1, ID is valid, and ex_rd equals IR[19:16], or equals IR[3:0] for register-form operands.
REQ-025 Per-edge priority SHALL be: rst > stall > flush > hazard > advance.
REQ-026 stall = 1: all stages SHALL hold.
REQ-027 Flush (branch_taken = 1): EX SHALL load a bubble, squashing the instruction in ID; exactly one bubble per taken branch.
REQ-028 hazard = 1 and no flush: EX SHALL load a bubble; later stages advance; upstream holds ID.
REQ-029 Advance: EX <= decoded word; stage k <= stage k-1 through N_STAGES.
REQ-030 branch_taken SHALL be asserted in the cycle EX holds b = 1 and SHALL deassert on the next advance.
REQ-031 Latency: ID to EX = 1 cycle; ID to WB = N_STAGES cycles, excluding stalled cycles.

Reset
REQ-032 rst SHALL clear all stage registers asynchronously to the bubble word, independent of clk.
REQ-033 With rst asserted, every output SHALL be 0, including branch_taken and hazard.
REQ-034 Reset asserted mid-stall or mid-flush SHALL discard all in-flight control.

Structure
REQ-035 A shared package SHALL hold the control-word struct, the opcode constants (ADD 0100, SUB 0010), the Sm/Mm encodings, the condition-code enum and the bubble constant.
REQ-036 Decode + condition evaluation SHALL be a combinational sub-module, ctrl_decode; the stage delay line SHALL live in ctrl_pipe_unit.

Verification
REQ-037 ir = E0821003 (ADD r1,r2,r3) with flags 0, then idle -> next cycle ex_op 0100, ex_sm 01, ex_rf_we 1, ex_rd 1; wb_rf_we 1 exactly N_STAGES cycles after issue.
REQ-038 ir = E5921000 (LDR r1,[r2]) then E0813004 (ADD r3,r1,r4) -> hazard 1 for one cycle, one bubble in EX, ADD reaches EX one cycle late.
REQ-039 ir = 0A000004 (BEQ) with flags 0100 -> branch_taken 1 in EX, following instruction squashed; with flags 0000 -> EX bubble, branch_taken 0.
REQ-040 ir = E5C21000 (STRB) -> ex_op 0100, ex_mm 00, ex_mem_we 1, ex_rf_we 0.
REQ-041 stall held 3 cycles mid-stream -> all outputs frozen; stream resumes without loss or duplication.
REQ-042 rst pulsed between clock edges with all stages full -> all outputs 0 immediately; first post-reset instruction decodes correctly.

Source files
------------

// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared definitions for the control pipeline: the control word, opcode and
// shifter/memory-size encodings, condition codes, the bubble word and the
// condition evaluation helper.
package ctrl_pipe_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0010;

  // Shifter mode
  localparam logic [1:0] SM_IMM = 2'b00;
  localparam logic [1:0] SM_REG = 2'b01;
  localparam logic [1:0] SM_MEM = 2'b10;

  // Memory access size
  localparam logic [1:0] MM_BYTE = 2'b00;
  localparam logic [1:0] MM_WORD = 2'b10;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] sm;
    logic [1:0] mm;
    logic       load;
    logic       rf_we;
    logic       mem_we;
    logic       data;
    logic       shift_imm;
    logic       b;
    logic [3:0] rd;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  // nzcv = {N, Z, C, V}; NV never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond_e'(cond))
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode and condition evaluation.
// Ports:
//   i_ir        instruction in ID
//   i_ir_valid  i_ir holds a real instruction
//   i_flags     NZCV
//   o_ctrl      decoded control word (bubble on invalid/undefined/failed cond)
//   o_rn        IR[19:16] source register
//   o_rm        IR[3:0] source register
//   o_rm_used   operand is register form, so o_rm is a real source
module ctrl_decode
  import ctrl_pipe_unit_pkg::*;
#(
  parameter bit COND_EN = 1'b1
) (
  input  logic [31:0] i_ir,
  input  logic        i_ir_valid,
  input  logic [3:0]  i_flags,
  output ctrl_word_t  o_ctrl,
  output logic [3:0]  o_rn,
  output logic [3:0]  o_rm,
  output logic        o_rm_used
);

  ctrl_word_t w_word;
  logic       w_pass;

  always_comb begin
    w_word    = CTRL_BUBBLE;
    o_rm_used = 1'b0;
    if (i_ir[27:26] == 2'b00) begin
      // Data processing
      w_word.op    = i_ir[24:21];
      w_word.rf_we = 1'b1;
      w_word.rd    = i_ir[15:12];
      if (i_ir[25]) begin
        w_word.sm        = SM_IMM;
        w_word.shift_imm = 1'b1;
      end else begin
        w_word.sm        = SM_REG;
        w_word.shift_imm = (i_ir[11:4] != 8'h00);
        o_rm_used        = 1'b1;
      end
    end else if (i_ir[27:26] == 2'b01) begin
      // Load/store: ALU forms the address, up/down picks add/sub
      w_word.op        = i_ir[23] ? OP_ADD : OP_SUB;
      w_word.sm        = SM_MEM;
      w_word.mm        = i_ir[22] ? MM_BYTE : MM_WORD;
      w_word.data      = 1'b1;
      w_word.load      = i_ir[20];
      w_word.rf_we     = i_ir[20];
      w_word.mem_we    = !i_ir[20];
      w_word.shift_imm = i_ir[25] ? (i_ir[11:4] != 8'h00) : 1'b1;
      w_word.rd        = i_ir[15:12];
      o_rm_used        = i_ir[25];
    end else if (i_ir[27:25] == 3'b101) begin
      w_word.b = 1'b1;
    end
  end

  assign w_pass = COND_EN ? cond_pass(i_ir[31:28], i_flags) : 1'b1;

  // An all-zero IR is a bubble, not ANDEQ r0,r0,r0.
  assign o_ctrl = (i_ir_valid && (i_ir != 32'h0) && w_pass) ? w_word : CTRL_BUBBLE;
  assign o_rn   = i_ir[19:16];
  assign o_rm   = i_ir[3:0];

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline: decodes the ID instruction and carries its control word
// from EX through N_STAGES register stages to WB. Handles global stall,
// taken-branch flush and load-use hazard bubbles.
// Ports:
//   clk, rst              clock, async active-high reset
//   ir, ir_valid, flags   ID instruction, valid, NZCV
//   stall                 global freeze
//   ex_*                  EX-stage control outputs
//   wb_rf_we/wb_load/wb_rd last-stage control outputs
//   hazard                combinational load-use stall request
//   branch_taken          registered, branch in EX passed its condition
module ctrl_pipe_unit
  import ctrl_pipe_unit_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter bit COND_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        ir_valid,
  input  logic        stall,
  input  logic [3:0]  flags,
  output logic [3:0]  ex_op,
  output logic [1:0]  ex_sm,
  output logic [1:0]  ex_mm,
  output logic        ex_load,
  output logic        ex_rf_we,
  output logic        ex_mem_we,
  output logic        ex_data,
  output logic        ex_shift_imm,
  output logic [3:0]  ex_rd,
  output logic        wb_rf_we,
  output logic        wb_load,
  output logic [3:0]  wb_rd,
  output logic        hazard,
  output logic        branch_taken
);

  ctrl_word_t w_dec;
  logic [3:0] w_rn;
  logic [3:0] w_rm;
  logic       w_rm_used;
  logic       w_hazard;

  // Index 0 is EX, index N_STAGES-1 is WB.
  ctrl_word_t r_stage [N_STAGES];
  logic       r_branch_taken;

  ctrl_decode #(
    .COND_EN(COND_EN)
  ) u_decode (
    .i_ir      (ir),
    .i_ir_valid(ir_valid),
    .i_flags   (flags),
    .o_ctrl    (w_dec),
    .o_rn      (w_rn),
    .o_rm      (w_rm),
    .o_rm_used (w_rm_used)
  );

  assign w_hazard = r_stage[0].load && ir_valid &&
                    ((r_stage[0].rd == w_rn) || (w_rm_used && (r_stage[0].rd == w_rm)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) begin
        r_stage[k] <= CTRL_BUBBLE;
      end
      r_branch_taken <= 1'b0;
    end else if (!stall) begin
      // Flush and hazard both drop a bubble into EX; they differ only in
      // whether upstream holds ID (hazard) or discards it (flush).
      if (r_branch_taken || w_hazard) begin
        r_stage[0]     <= CTRL_BUBBLE;
        r_branch_taken <= 1'b0;
      end else begin
        r_stage[0]     <= w_dec;
        r_branch_taken <= w_dec.b;
      end
      for (int k = 1; k < N_STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign ex_op        = r_stage[0].op;
  assign ex_sm        = r_stage[0].sm;
  assign ex_mm        = r_stage[0].mm;
  assign ex_load      = r_stage[0].load;
  assign ex_rf_we     = r_stage[0].rf_we;
  assign ex_mem_we    = r_stage[0].mem_we;
  assign ex_data      = r_stage[0].data;
  assign ex_shift_imm = r_stage[0].shift_imm;
  assign ex_rd        = r_stage[0].rd;
  assign wb_rf_we     = r_stage[N_STAGES-1].rf_we;
  assign wb_load      = r_stage[N_STAGES-1].load;
  assign wb_rd        = r_stage[N_STAGES-1].rd;
  assign hazard       = w_hazard;
  assign branch_taken = r_branch_taken;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: stimulus pushes hand-computed EX and
// WB control words into queues; a monitor pops and compares them whenever a
// non-bubble word appears in EX or a register write appears at WB.
module tb_ctrl_pipe_unit;

  localparam int NS = 3;

  // {op, sm, mm, load, rf_we, mem_we, data, shift_imm, branch_taken, rd}
  localparam logic [17:0] V_ADD1   = 18'b0100_01_00_0_1_0_0_0_0_0001; // E0821003
  localparam logic [17:0] V_ADDS1  = 18'b0100_01_00_0_1_0_0_1_0_0001; // E0821083
  localparam logic [17:0] V_LDR1   = 18'b0100_10_10_1_1_0_1_1_0_0001; // E5921000
  localparam logic [17:0] V_ADD3   = 18'b0100_01_00_0_1_0_0_0_0_0011; // E0813004
  localparam logic [17:0] V_SUB5   = 18'b0010_01_00_0_1_0_0_0_0_0101; // E0435006
  localparam logic [17:0] V_ADDI7  = 18'b0100_00_00_0_1_0_0_1_0_0111; // E2827005
  localparam logic [17:0] V_BEQ    = 18'b0000_00_00_0_0_0_0_0_1_0000; // 0A000004
  localparam logic [17:0] V_STRB   = 18'b0100_10_00_0_0_1_1_1_0_0001; // E5C21000
  localparam logic [17:0] V_ADD2R  = 18'b0100_01_00_0_1_0_0_0_0_0010; // E0832001
  localparam logic [17:0] V_ADDI2  = 18'b0100_00_00_0_1_0_0_1_0_0010; // E2832001
  localparam logic [17:0] V_LDRSUB = 18'b0010_10_10_1_1_0_1_0_0_0001; // E7121003

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        ir_valid;
  logic        stall;
  logic [3:0]  flags;
  logic [3:0]  ex_op;
  logic [1:0]  ex_sm;
  logic [1:0]  ex_mm;
  logic        ex_load;
  logic        ex_rf_we;
  logic        ex_mem_we;
  logic        ex_data;
  logic        ex_shift_imm;
  logic [3:0]  ex_rd;
  logic        wb_rf_we;
  logic        wb_load;
  logic [3:0]  wb_rd;
  logic        hazard;
  logic        branch_taken;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(
    .N_STAGES(NS),
    .COND_EN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .stall       (stall),
    .flags       (flags),
    .ex_op       (ex_op),
    .ex_sm       (ex_sm),
    .ex_mm       (ex_mm),
    .ex_load     (ex_load),
    .ex_rf_we    (ex_rf_we),
    .ex_mem_we   (ex_mem_we),
    .ex_data     (ex_data),
    .ex_shift_imm(ex_shift_imm),
    .ex_rd       (ex_rd),
    .wb_rf_we    (wb_rf_we),
    .wb_load     (wb_load),
    .wb_rd       (wb_rd),
    .hazard      (hazard),
    .branch_taken(branch_taken)
  );

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          adv_cnt = 0;
  int          hz_cnt  = 0;
  bit          moved   = 1'b0;
  logic [17:0] mon_v;
  logic [17:0] exp_ex [$];
  logic [4:0]  exp_wb [$];
  int          ex_times [$];

  function automatic logic [17:0] ex_vec();
    return {ex_op, ex_sm, ex_mm, ex_load, ex_rf_we, ex_mem_we, ex_data, ex_shift_imm,
            branch_taken, ex_rd};
  endfunction

  function automatic logic [24:0] all_out();
    return {ex_vec(), wb_rf_we, wb_load, wb_rd, hazard};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_word(input logic [17:0] v);
    exp_ex.push_back(v);
    if (v[8]) exp_wb.push_back({v[9], v[3:0]});
  endtask

  // Present one instruction in ID; hold it while hazard or stall is raised.
  task automatic drive(input logic [31:0] i, input logic v, output int cyc);
    int hold;
    ir       = i;
    ir_valid = v;
    cyc      = 0;
    do begin
      @(negedge clk);
      hold = (hazard || stall) ? 1 : 0;
      if (hazard) hz_cnt++;
      @(posedge clk);
      #2;
      cyc++;
    end while (hold != 0 && cyc < 20);
    check("accept_timeout", hold, 0);
    ir       = 32'h0;
    ir_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ir       = 32'h0;
    ir_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  always @(posedge clk) begin
    moved = !rst && !stall;
    if (moved) adv_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && moved) begin
      mon_v = ex_vec();
      if (mon_v != 18'h0) begin
        if (exp_ex.size() == 0) check("ex_unexpected", mon_v, 0);
        else check("ex_word", mon_v, exp_ex.pop_front());
        if (ex_rf_we) ex_times.push_back(adv_cnt);
      end
      if (wb_rf_we) begin
        if (exp_wb.size() == 0) check("wb_unexpected", {wb_load, wb_rd}, 0);
        else check("wb_word", {wb_load, wb_rd}, exp_wb.pop_front());
        if (ex_times.size() == 0) check("wb_untracked", 1, 0);
        else check("wb_latency", adv_cnt - ex_times.pop_front(), NS - 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int e;
    rst      = 1'b1;
    ir       = 32'h0;
    ir_valid = 1'b0;
    stall    = 1'b0;
    flags    = 4'h0;
    #1;
    check("reset_outputs", all_out(), 0);
    ir       = 32'hE5921000;
    ir_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_held_outputs", all_out(), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Basic ADD: one cycle to EX, NS cycles to WB
    expect_word(V_ADD1);
    drive(32'hE0821003, 1'b1, c);
    check("add_id_to_ex", c, 1);
    check("add_ex_op_sm_rd", {ex_op, ex_sm, ex_rf_we, ex_rd}, {4'b0100, 2'b01, 1'b1, 4'd1});
    e = 1;
    while (!wb_rf_we && e < 10) begin
      @(posedge clk);
      #2;
      e++;
    end
    check("add_wb_cycles", e, NS);
    idle(3);

    // Decode variety, back to back
    expect_word(V_ADDS1);
    drive(32'hE0821083, 1'b1, c);
    expect_word(V_ADDI7);
    drive(32'hE2827005, 1'b1, c);
    expect_word(V_SUB5);
    drive(32'hE0435006, 1'b1, c);
    expect_word(V_STRB);
    drive(32'hE5C21000, 1'b1, c);
    check("strb_ctrl", {ex_op, ex_mm, ex_mem_we, ex_rf_we}, {4'b0100, 2'b00, 1'b1, 1'b0});
    drive(32'h0, 1'b1, c);
    check("zero_ir_bubble", ex_vec(), 0);
    drive(32'hE0821003, 1'b0, c);
    check("invalid_bubble", ex_vec(), 0);
    expect_word(V_LDRSUB);
    drive(32'hE7121003, 1'b1, c);
    idle(3);

    // Load-use hazard on Rn
    hz_cnt = 0;
    expect_word(V_LDR1);
    drive(32'hE5921000, 1'b1, c);
    expect_word(V_ADD3);
    drive(32'hE0813004, 1'b1, c);
    check("hazard_rn_cycles", hz_cnt, 1);
    check("hazard_rn_delay", c, 2);
    idle(3);

    // Load-use hazard on Rm
    hz_cnt = 0;
    expect_word(V_LDR1);
    drive(32'hE5921000, 1'b1, c);
    expect_word(V_ADD2R);
    drive(32'hE0832001, 1'b1, c);
    check("hazard_rm_cycles", hz_cnt, 1);
    idle(3);

    // Immediate form: IR[3:0] matches but is not a register
    hz_cnt = 0;
    expect_word(V_LDR1);
    drive(32'hE5921000, 1'b1, c);
    expect_word(V_ADDI2);
    drive(32'hE2832001, 1'b1, c);
    check("no_hazard_imm", hz_cnt, 0);
    check("no_hazard_imm_delay", c, 1);
    idle(3);

    // Invalid ID never raises hazard
    hz_cnt = 0;
    expect_word(V_LDR1);
    drive(32'hE5921000, 1'b1, c);
    drive(32'hE0813004, 1'b0, c);
    check("no_hazard_invalid", hz_cnt, 0);
    idle(3);

    // Conditions with Z set
    flags = 4'b0100;
    drive(32'h10821003, 1'b1, c);
    check("cond_ne_fail", ex_vec(), 0);
    drive(32'hF0821003, 1'b1, c);
    check("cond_nv_fail", ex_vec(), 0);
    expect_word(V_ADD1);
    drive(32'h00821003, 1'b1, c);
    idle(3);

    // Taken branch squashes the next instruction
    expect_word(V_BEQ);
    drive(32'h0A000004, 1'b1, c);
    check("beq_taken", branch_taken, 1);
    drive(32'hE0821003, 1'b1, c);
    check("flush_bt_clear", branch_taken, 0);
    check("flush_bubble", ex_vec(), 0);
    expect_word(V_ADDI7);
    drive(32'hE2827005, 1'b1, c);
    idle(3);

    // Not-taken branch: bubble, no squash
    flags = 4'b0000;
    drive(32'h0A000004, 1'b1, c);
    check("beq_not_taken", branch_taken, 0);
    check("beq_not_taken_bubble", ex_vec(), 0);
    expect_word(V_ADD1);
    drive(32'hE0821003, 1'b1, c);
    idle(4);

    // Stall 3 cycles mid-stream
    expect_word(V_ADD1);
    drive(32'hE0821003, 1'b1, c);
    expect_word(V_SUB5);
    drive(32'hE0435006, 1'b1, c);
    expect_word(V_ADDI7);
    drive(32'hE2827005, 1'b1, c);
    stall    = 1'b1;
    ir       = 32'hE0813004;
    ir_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("stall_ex_frozen", ex_vec(), V_ADDI7);
      check("stall_wb_frozen", {wb_rf_we, wb_load, wb_rd}, {1'b1, 1'b0, 4'd1});
    end
    stall = 1'b0;
    expect_word(V_ADD3);
    drive(32'hE0813004, 1'b1, c);
    check("stall_resume_delay", c, 1);
    idle(4);

    // Async reset mid-stall with the pipe full
    expect_word(V_ADD1);
    drive(32'hE0821003, 1'b1, c);
    expect_word(V_SUB5);
    drive(32'hE0435006, 1'b1, c);
    expect_word(V_LDR1);
    drive(32'hE5921000, 1'b1, c);
    stall    = 1'b1;
    ir       = 32'hE0813004;
    ir_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", all_out(), 0);
    exp_ex.delete();
    exp_wb.delete();
    ex_times.delete();
    rst      = 1'b0;
    stall    = 1'b0;
    ir       = 32'h0;
    ir_valid = 1'b0;
    idle(1);
    expect_word(V_ADDI7);
    drive(32'hE2827005, 1'b1, c);
    check("post_reset_decode", ex_vec(), V_ADDI7);
    idle(5);

    check("ex_queue_drained", exp_ex.size(), 0);
    check("wb_queue_drained", exp_wb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
